rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Round-robin arbiter that shares the single write port of the 16 x 16-bit `RegisterFile` between two writeback requesters. Requester 0 is the ALU writeback and requester 1 is the load writeback. Each requester uses a valid/ready handshake. The arbiter accepts at most one write per cycle and registers it onto the `RegisterFile` write-port signals `dstReg`, `writeReg` and `dstData`. It also keeps a saturating contention counter for performance monitoring.

## Interface
Parameters:
- DATA_W, 16, data width of a register-file word
- ADDR_W, 4, register index width (16 registers)
- CNT_W, 16, contention counter width

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  ALU writeback request
- req0_reg  in  ADDR_W  destination register of request 0
- req0_data  in  DATA_W  write data of request 0
- req0_ready  out  1  request 0 accepted this cycle
- req1_valid  in  1  load writeback request
- req1_reg  in  ADDR_W  destination register of request 1
- req1_data  in  DATA_W  write data of request 1
- req1_ready  out  1  request 1 accepted this cycle
- dstReg  out  ADDR_W  register-file write index (registered)
- writeReg  out  1  register-file write enable (registered)
- dstData  out  DATA_W  register-file write data (registered)
- last_grant  out  1  requester that won the most recent grant
- contention_cnt  out  CNT_W  number of cycles in which both requesters were valid; saturating

## Operation
- Single clock `clk`. Reset `rst` is synchronous and active-high. Reset values:
  - `writeReg`=0, `dstReg`=0, `dstData`=0
  - `last_grant`=1, so requester 0 has priority in the first cycle after reset
  - `contention_cnt`=0
- Handshake: a transfer occurs for requester i in a cycle where `reqi_valid && reqi_ready` are both high at the rising edge.
  - Once a requester raises valid, it holds valid, reg and data stable until the transfer.
  - A requester never makes its valid depend on its ready.
- Grant rules (combinational from the current inputs and `last_grant`):
  - Only one requester valid: that requester gets ready=1.
  - Both valid: the requester not equal to `last_grant` gets ready=1; the other gets ready=0.
  - Neither valid: both readies are 0.
  - Ready is never asserted to a requester whose valid is low.
  - Outside reset, at most one ready is high in any cycle.
- Grant state: on each transfer, `last_grant` is loaded with the index of the granted requester. With no transfer, `last_grant` holds.
- Write-port stage (single state bit: IDLE when `writeReg`=0, WRITE when `writeReg`=1):
  - Transfer in cycle N: in cycle N+1, `writeReg`=1 and `dstReg`/`dstData` carry the granted request's reg and data.
  - No transfer in cycle N: in cycle N+1, `writeReg`=0; `dstReg` and `dstData` hold their previous values.
  - This stage is never back-pressured, because the register file accepts one write every cycle.
- Same destination register: if both requesters are valid with the same destination, the writes commit in grant order, so the later grant's data is the final register value. No merging or dropping.
- Contention counter: increments in every cycle where both valids are high and `rst`=0. It saturates at 2^CNT_W-1 and does not wrap.
- Reset during operation: a transfer is not recorded in the cycle `rst` is high. Both readies are forced to 0 while `rst`=1. Any write queued in the write-port stage is discarded (`writeReg`=0 in the following cycle).

## Timing
- Accept-to-write latency is exactly 1 cycle. The data is visible in the `RegisterFile` after the rising edge that ends cycle N+1.
- `reqi_ready` is purely combinational from the valids and `last_grant`. No register sits between valid and ready.
- Throughput is one write per cycle. With both requesters continuously valid, grants alternate 0,1,0,1...
- Starvation bound: a requester that holds valid high waits at most 1 cycle before it is granted.

## Structure
- Shared package `rf_pkg`:
  - constants RF_DATA_W=16, RF_ADDR_W=4, RF_NUM_REGS=16
  - typedef `rf_wr_req_t` {valid, reg, data}
  - This package is the same one used by `RegisterFile` and the decoders.
- Sub-module `rr_arb2`: a 2-requester round-robin grant generator that holds the `last_grant` pointer. The write-port stage register and the contention counter stay in the top module.

## Test plan
- Reset behaviour: assert `rst` for 2 cycles with both valids high → readies are 0 throughout, `writeReg`=0, `contention_cnt`=0; in the first cycle after reset, req0 is granted.
- Single requester: req1 valid with reg=5, data=16'hBEEF for one cycle → req1_ready=1 that cycle; in the next cycle, `writeReg`=1, `dstReg`=5, `dstData`=16'hBEEF; a subsequent read of r5 through `srcReg_1` returns 16'hBEEF.
- Alternation: both requesters valid for 6 cycles with distinct data → grant order 0,1,0,1,0,1; `contention_cnt` equals the number of both-valid cycles (6, or 5 if one requester drops valid after its last grant); no cycle has both readies high.
- Same destination: req0 (r3, 16'h1111) and req1 (r3, 16'h2222) raised together after reset → two writes, req0's first; r3 ends at 16'h2222.
- Reset during operation: assert `rst` in the cycle after a transfer → `writeReg`=0 in the next cycle; the register file entry is unchanged; `last_grant`=1 afterwards.
- Saturation: with CNT_W=4, hold both valids high for 20 cycles → `contention_cnt` stops at 15.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file constants and write-request types
package rf_pkg;
  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 4;
  localparam int RF_NUM_REGS = 16;
  typedef struct packed {
    logic valid;
    logic [RF_ADDR_W-1:0] idx;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_req_t;
  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} wr_state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin grant generator holding the last-grant pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] ready,
  output logic       lastGrant
);
  always_comb ready = rst ? 2'b00 : (&valid) ? (lastGrant ? 2'b01 : 2'b10) : valid;
  always_ff @(posedge clk)
    if (rst) lastGrant <= 1'b1;
    else if (|ready) lastGrant <= ready[1];
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin share of the register-file write port between ALU and load writeback
module rf_write_arbiter import rf_pkg::*; #(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] dstReg,
  output logic              writeReg,
  output logic [DATA_W-1:0] dstData,
  output logic              last_grant,
  output logic [CNT_W-1:0]  contention_cnt
);
  logic [1:0] ready;
  wr_state_t state, nextState;
  rr_arb2 arb (
    .clk(clk),
    .rst(rst),
    .valid({req1_valid, req0_valid}),
    .ready(ready),
    .lastGrant(last_grant)
  );
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign writeReg = (state == WRITE);
  always_comb nextState = (|ready) ? WRITE : IDLE;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nextState;
  always_ff @(posedge clk)
    if (rst) begin
      dstReg <= '0;
      dstData <= '0;
    end else if (|ready) begin
      dstReg <= ready[1] ? req1_reg : req0_reg;
      dstData <= ready[1] ? req1_data : req0_data;
    end
  // saturates instead of wrapping so monitoring never under-reports
  always_ff @(posedge clk)
    if (rst) contention_cnt <= '0;
    else if (req0_valid && req1_valid && contention_cnt != '1) contention_cnt <= contention_cnt + 1'b1;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;
  logic clk = 0;
  logic rst;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0] req0_reg, req1_reg, dstReg;
  logic [15:0] req0_data, req1_data, dstData;
  logic writeReg, last_grant;
  logic [3:0] contention_cnt;
  logic [15:0] rf [16];
  int checks = 0;
  int errors = 0;
  logic [15:0] d0, d1;

  rf_write_arbiter #(.DATA_W(16), .ADDR_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .dstReg(dstReg), .writeReg(writeReg), .dstData(dstData),
    .last_grant(last_grant), .contention_cnt(contention_cnt)
  );

  always #5 clk = ~clk;

  // behavioural register file fed by the write port
  initial for (int i = 0; i < 16; i++) rf[i] = '0;
  always @(posedge clk) if (writeReg) rf[dstReg] <= dstData;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1;
    req0_valid = 1; req0_reg = 4'd1; req0_data = 16'h00A0;
    req1_valid = 1; req1_reg = 4'd2; req1_data = 16'h00B0;
    repeat (2) begin
      cyc();
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_writeReg", writeReg, 0);
      chk("rst_cnt", contention_cnt, 0);
      chk("rst_last_grant", last_grant, 1);
    end
    rst = 0;
    #1;
    chk("first_ready0", req0_ready, 1);
    chk("first_ready1", req1_ready, 0);
    cyc();
    chk("first_wr", writeReg, 1);
    chk("first_dst", dstReg, 1);
    chk("first_data", dstData, 16'h00A0);
    chk("first_cnt", contention_cnt, 1);
    chk("first_last", last_grant, 0);
    req0_valid = 0;
    #1;
    chk("second_ready1", req1_ready, 1);
    cyc();
    chk("second_dst", dstReg, 2);
    chk("second_data", dstData, 16'h00B0);
    chk("second_cnt", contention_cnt, 1);
    req1_valid = 0;
    #1;
    chk("idle_ready0", req0_ready, 0);
    chk("idle_ready1", req1_ready, 0);
    cyc();
    chk("idle_wr", writeReg, 0);
    chk("idle_dst_hold", dstReg, 2);
    chk("idle_data_hold", dstData, 16'h00B0);

    req1_valid = 1; req1_reg = 4'd5; req1_data = 16'hBEEF;
    #1;
    chk("single_ready1", req1_ready, 1);
    chk("single_ready0", req0_ready, 0);
    cyc();
    chk("single_wr", writeReg, 1);
    chk("single_dst", dstReg, 5);
    chk("single_data", dstData, 16'hBEEF);
    req1_valid = 0;
    cyc();
    chk("single_rf5", rf[5], 16'hBEEF);
    chk("single_wr_off", writeReg, 0);

    d0 = 16'h1000; d1 = 16'h2000;
    req0_valid = 1; req0_reg = 4'd6; req0_data = d0;
    req1_valid = 1; req1_reg = 4'd7; req1_data = d1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("alt_ready0", req0_ready, (i % 2 == 0));
      chk("alt_ready1", req1_ready, (i % 2 == 1));
      chk("alt_onehot", req0_ready & req1_ready, 0);
      cyc();
      chk("alt_wr", writeReg, 1);
      chk("alt_dst", dstReg, (i % 2) ? 4'd7 : 4'd6);
      chk("alt_data", dstData, (i % 2) ? d1 : d0);
      if (i % 2) begin d1 = d1 + 1; req1_data = d1; end
      else begin d0 = d0 + 1; req0_data = d0; end
    end
    chk("alt_cnt", contention_cnt, 7);
    req0_valid = 0; req1_valid = 0;
    cyc();
    chk("alt_rf6", rf[6], 16'h1002);
    chk("alt_rf7", rf[7], 16'h2002);

    rst = 1;
    cyc();
    rst = 0;
    chk("rst2_cnt", contention_cnt, 0);
    req0_valid = 1; req0_reg = 4'd3; req0_data = 16'h1111;
    req1_valid = 1; req1_reg = 4'd3; req1_data = 16'h2222;
    #1;
    chk("same_ready0", req0_ready, 1);
    cyc();
    chk("same_data0", dstData, 16'h1111);
    chk("same_dst0", dstReg, 3);
    req0_valid = 0;
    #1;
    chk("same_ready1", req1_ready, 1);
    cyc();
    chk("same_data1", dstData, 16'h2222);
    req1_valid = 0;
    cyc();
    chk("same_rf3", rf[3], 16'h2222);
    chk("same_cnt", contention_cnt, 1);

    req0_valid = 1; req0_reg = 4'd9; req0_data = 16'h5A5A;
    #1;
    chk("ro_ready0", req0_ready, 1);
    cyc();
    chk("ro_wr", writeReg, 1);
    chk("ro_last", last_grant, 0);
    req0_reg = 4'd10; req0_data = 16'h7777;
    rst = 1;
    #1;
    chk("ro_rst_ready0", req0_ready, 0);
    chk("ro_rst_ready1", req1_ready, 0);
    cyc();
    chk("ro_wr_off", writeReg, 0);
    chk("ro_last_rst", last_grant, 1);
    chk("ro_cnt", contention_cnt, 0);
    rst = 0; req0_valid = 0;
    cyc();
    chk("ro_rf10", rf[10], 16'h0000);
    chk("ro_wr_idle", writeReg, 0);

    req0_valid = 1; req0_reg = 4'd11; req0_data = 16'hAAAA;
    req1_valid = 1; req1_reg = 4'd12; req1_data = 16'hCCCC;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i == 13) chk("sat_cnt14", contention_cnt, 14);
    end
    chk("sat_cnt", contention_cnt, 15);
    req0_valid = 0; req1_valid = 0;
    cyc();
    chk("sat_hold", contention_cnt, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
